// File: rtl/b10_link_pkg.sv
// rtl/b10_link_pkg.sv - shared types, sizes and helpers for the b10 link peer
package b10_link_pkg;

    localparam int FIFO_DEPTH = 4;
    localparam int WORD_W     = 4;
    localparam int WAIT_W     = 8;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [WAIT_W-1:0] wait_t;

    typedef enum logic [1:0] {
        TX_IDLE = 2'd0,
        TX_REQ  = 2'd1,
        TX_REL  = 2'd2
    } tx_state_e;

    typedef enum logic [1:0] {
        RX_IDLE = 2'd0,
        RX_WAIT = 2'd1,
        RX_REL  = 2'd2
    } rx_state_e;

    function automatic wait_t sat_inc(input wait_t v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    // A zero configuration disables the timeout entirely.
    function automatic logic hit_timeout(input wait_t cnt_next, input wait_t cfg);
        return (cfg != '0) && (cnt_next >= cfg);
    endfunction

endpackage

// File: rtl/b10_link_peer_if.sv
// rtl/b10_link_peer_if.sv - host streams, link handshakes and control bundle
interface b10_link_peer_if;
    import b10_link_pkg::*;

    logic  tx_valid;
    word_t tx_data;
    logic  tx_ready;

    logic  rx_valid;
    word_t rx_data;
    logic  rx_ready;

    logic  rts;
    word_t v_in;
    logic  cts;

    logic  rtr;
    logic  ctr;
    word_t v_out;

    logic  rx_en;
    wait_t timeout_cfg;
    logic  err_timeout;
    logic  clr_err;

    modport master (
        output tx_valid, tx_data, rx_ready, cts, ctr, v_out, rx_en, timeout_cfg, clr_err,
        input  tx_ready, rx_valid, rx_data, rts, v_in, rtr, err_timeout
    );

    modport slave (
        input  tx_valid, tx_data, rx_ready, cts, ctr, v_out, rx_en, timeout_cfg, clr_err,
        output tx_ready, rx_valid, rx_data, rts, v_in, rtr, err_timeout
    );

endinterface

// File: rtl/b10_link_fifo.sv
// rtl/b10_link_fifo.sv - small circular FIFO with stream-style push and pop sides
module b10_link_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_tvalid,
    input  logic [WIDTH-1:0] in_tdata,
    output logic             in_tready,
    output logic             out_tvalid,
    output logic [WIDTH-1:0] out_tdata,
    input  logic             out_tready
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push;
    logic             pop;

    assign in_tready  = (count_q != FULL_CNT);
    assign out_tvalid = (count_q != '0);
    // Head reads as zero while empty so stale words never leak out.
    assign out_tdata  = out_tvalid ? mem_q[rd_ptr_q] : '0;
    assign push       = in_tvalid && in_tready;
    assign pop        = out_tvalid && out_tready;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = in_tdata;
            wr_ptr_d        = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/b10_link_peer.sv
// rtl/b10_link_peer.sv - buffered four-phase send/receive link peer with handshake timeout
module b10_link_peer
    import b10_link_pkg::*;
(
    input  logic           clock,
    input  logic           reset,
    b10_link_peer_if.slave lnk
);
    word_t     tx_head;
    logic      tx_nonempty;
    logic      tx_ready_w;
    logic      tx_pop;
    word_t     rx_head;
    logic      rx_valid_w;
    logic      rx_space;
    logic      rx_pop;
    logic      rx_push;
    logic      rx_free;

    tx_state_e tx_state_q, tx_state_d;
    wait_t     tx_cnt_q, tx_cnt_d, tx_cnt_inc;
    logic      rts_q, rts_d;
    word_t     v_in_q, v_in_d;
    logic      tx_to;

    rx_state_e rx_state_q, rx_state_d;
    wait_t     rx_cnt_q, rx_cnt_d, rx_cnt_inc;
    logic      rtr_q, rtr_d;
    logic      rx_to;

    logic      err_q, err_d;

    b10_link_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(WORD_W)) u_tx_fifo (
        .clk        (clock),
        .rst_n      (reset),
        .in_tvalid  (lnk.tx_valid),
        .in_tdata   (lnk.tx_data),
        .in_tready  (tx_ready_w),
        .out_tvalid (tx_nonempty),
        .out_tdata  (tx_head),
        .out_tready (tx_pop)
    );

    b10_link_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(WORD_W)) u_rx_fifo (
        .clk        (clock),
        .rst_n      (reset),
        .in_tvalid  (rx_push),
        .in_tdata   (lnk.v_out),
        .in_tready  (rx_space),
        .out_tvalid (rx_valid_w),
        .out_tdata  (rx_head),
        .out_tready (lnk.rx_ready)
    );

    assign tx_pop  = (tx_state_q == TX_REQ) && lnk.cts;
    assign rx_push = (rx_state_q == RX_WAIT) && lnk.ctr;
    assign rx_pop  = rx_valid_w && lnk.rx_ready;
    // A host pop on this edge frees a slot just as well as an already-free one.
    assign rx_free = rx_space || rx_pop;

    assign tx_cnt_inc = sat_inc(tx_cnt_q);
    assign rx_cnt_inc = sat_inc(rx_cnt_q);

    // A cts arriving on the same edge as the timeout completes the handshake.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        rts_d      = rts_q;
        v_in_d     = v_in_q;
        tx_to      = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                tx_cnt_d = '0;
                if (tx_nonempty) begin
                    tx_state_d = TX_REQ;
                    rts_d      = 1'b1;
                    v_in_d     = tx_head;
                end
            end
            TX_REQ: begin
                if (lnk.cts) begin
                    tx_state_d = TX_REL;
                    rts_d      = 1'b0;
                    tx_cnt_d   = '0;
                end else if (hit_timeout(tx_cnt_inc, lnk.timeout_cfg)) begin
                    tx_state_d = TX_IDLE;
                    rts_d      = 1'b0;
                    tx_cnt_d   = '0;
                    tx_to      = 1'b1;
                end else begin
                    tx_cnt_d = tx_cnt_inc;
                end
            end
            TX_REL: begin
                if (!lnk.cts) begin
                    tx_state_d = TX_IDLE;
                    tx_cnt_d   = '0;
                end else if (hit_timeout(tx_cnt_inc, lnk.timeout_cfg)) begin
                    tx_state_d = TX_IDLE;
                    tx_cnt_d   = '0;
                    tx_to      = 1'b1;
                end else begin
                    tx_cnt_d = tx_cnt_inc;
                end
            end
            default: begin
                tx_state_d = TX_IDLE;
                tx_cnt_d   = '0;
                rts_d      = 1'b0;
            end
        endcase
    end

    // rx_en only gates entry; a wait already in progress runs to completion.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rtr_d      = rtr_q;
        rx_to      = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = '0;
                if (lnk.rx_en && rx_free) begin
                    rx_state_d = RX_WAIT;
                    rtr_d      = 1'b1;
                end
            end
            RX_WAIT: begin
                if (lnk.ctr) begin
                    rx_state_d = RX_REL;
                    rtr_d      = 1'b0;
                    rx_cnt_d   = '0;
                end else if (hit_timeout(rx_cnt_inc, lnk.timeout_cfg)) begin
                    rx_state_d = RX_IDLE;
                    rtr_d      = 1'b0;
                    rx_cnt_d   = '0;
                    rx_to      = 1'b1;
                end else begin
                    rx_cnt_d = rx_cnt_inc;
                end
            end
            RX_REL: begin
                if (!lnk.ctr) begin
                    rx_state_d = RX_IDLE;
                    rx_cnt_d   = '0;
                end else if (hit_timeout(rx_cnt_inc, lnk.timeout_cfg)) begin
                    rx_state_d = RX_IDLE;
                    rx_cnt_d   = '0;
                    rx_to      = 1'b1;
                end else begin
                    rx_cnt_d = rx_cnt_inc;
                end
            end
            default: begin
                rx_state_d = RX_IDLE;
                rx_cnt_d   = '0;
                rtr_d      = 1'b0;
            end
        endcase
    end

    // Setting wins over clearing so a coincident timeout is never lost.
    always_comb begin
        err_d = err_q;
        if (tx_to || rx_to) begin
            err_d = 1'b1;
        end else if (lnk.clr_err) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            rts_q      <= 1'b0;
            v_in_q     <= '0;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rtr_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            rts_q      <= rts_d;
            v_in_q     <= v_in_d;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rtr_q      <= rtr_d;
            err_q      <= err_d;
        end
    end

    assign lnk.tx_ready    = tx_ready_w;
    assign lnk.rx_valid    = rx_valid_w;
    assign lnk.rx_data     = rx_head;
    assign lnk.rts         = rts_q;
    assign lnk.v_in        = v_in_q;
    assign lnk.rtr         = rtr_q;
    assign lnk.err_timeout = err_q;

endmodule

// File: tb/tb_b10_link_peer.sv
// tb/tb_b10_link_peer.sv - vector table, corner sequences and randomized scoreboard for b10_link_peer
module tb_b10_link_peer;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_err;
    int   n_tx;
    int   n_rx;

    b10_link_peer_if lk ();

    b10_link_peer dut (
        .clock (clk),
        .reset (rst_n),
        .lnk   (lk)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       tx_valid;
        logic [3:0] tx_data;
        logic       cts;
        logic       rx_en;
        logic       ctr;
        logic [3:0] v_out;
        logic       rx_ready;
        logic       e_rts;
        logic [3:0] e_v_in;
        logic       e_tx_ready;
        logic       e_rtr;
        logic       e_rx_valid;
        logic [3:0] e_rx_data;
    } vec_t;

    vec_t       vecs [10];
    logic [3:0] mtx [$];
    logic [3:0] mrx [$];
    logic [3:0] w4 [4];
    logic       ev_push, ev_pop, ev_rin, ev_rout, seen;
    logic [3:0] ev_tdata, ev_vout;
    int         hi, k;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        lk.tx_valid    = 1'b0;
        lk.tx_data     = 4'h0;
        lk.rx_ready    = 1'b0;
        lk.cts         = 1'b0;
        lk.ctr         = 1'b0;
        lk.v_out       = 4'h0;
        lk.rx_en       = 1'b0;
        lk.timeout_cfg = 8'd0;
        lk.clr_err     = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive_idle();
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic tx_expect(input logic [3:0] w, input string nm);
        int n;
        n = 0;
        while (!lk.rts && n < 30) begin
            step();
            n++;
        end
        chk({nm, " rts"}, lk.rts, 1);
        chk({nm, " v_in"}, lk.v_in, w);
        lk.cts = 1'b1;
        step();
        lk.cts = 1'b0;
        step();
    endtask

    task automatic rx_give(input logic [3:0] w, input string nm);
        int n;
        n = 0;
        while (!lk.rtr && n < 30) begin
            step();
            n++;
        end
        chk({nm, " rtr"}, lk.rtr, 1);
        lk.v_out = w;
        lk.ctr   = 1'b1;
        step();
        lk.ctr = 1'b0;
        step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        n_chk = 0;
        n_err = 0;
        n_tx  = 0;
        n_rx  = 0;

        //        tv    td    cts   en    ctr   vo    rr  | rts   vin   trdy  rtr   rv    rd
        vecs[0] = '{1'b1, 4'hA, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0};
        vecs[1] = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 4'hA, 1'b1, 1'b0, 1'b0, 4'h0};
        vecs[2] = '{1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'hA, 1'b1, 1'b0, 1'b0, 4'h0};
        vecs[3] = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'hA, 1'b1, 1'b0, 1'b0, 4'h0};
        vecs[4] = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'hA, 1'b1, 1'b0, 1'b0, 4'h0};
        vecs[5] = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 4'hA, 1'b1, 1'b1, 1'b0, 4'h0};
        vecs[6] = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 4'hA, 1'b1, 1'b1, 1'b0, 4'h0};
        vecs[7] = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 4'h5, 1'b0, 1'b0, 4'hA, 1'b1, 1'b0, 1'b1, 4'h5};
        vecs[8] = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'hA, 1'b1, 1'b0, 1'b1, 4'h5};
        vecs[9] = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 4'hA, 1'b1, 1'b0, 1'b0, 4'h0};

        rst_n = 1'b0;
        drive_idle();
        step();
        chk("reset rts", lk.rts, 0);
        chk("reset rtr", lk.rtr, 0);
        chk("reset v_in", lk.v_in, 0);
        chk("reset tx_ready", lk.tx_ready, 1);
        chk("reset rx_valid", lk.rx_valid, 0);
        chk("reset rx_data", lk.rx_data, 0);
        chk("reset err_timeout", lk.err_timeout, 0);
        rst_n = 1'b1;

        // Single send with cts echoing rts one cycle late, then a single receive
        for (int i = 0; i < 10; i++) begin
            lk.tx_valid = vecs[i].tx_valid;
            lk.tx_data  = vecs[i].tx_data;
            lk.cts      = vecs[i].cts;
            lk.rx_en    = vecs[i].rx_en;
            lk.ctr      = vecs[i].ctr;
            lk.v_out    = vecs[i].v_out;
            lk.rx_ready = vecs[i].rx_ready;
            step();
            chk($sformatf("vec%0d rts", i), lk.rts, vecs[i].e_rts);
            chk($sformatf("vec%0d v_in", i), lk.v_in, vecs[i].e_v_in);
            chk($sformatf("vec%0d tx_ready", i), lk.tx_ready, vecs[i].e_tx_ready);
            chk($sformatf("vec%0d rtr", i), lk.rtr, vecs[i].e_rtr);
            chk($sformatf("vec%0d rx_valid", i), lk.rx_valid, vecs[i].e_rx_valid);
            if (vecs[i].e_rx_valid) begin
                chk($sformatf("vec%0d rx_data", i), lk.rx_data, vecs[i].e_rx_data);
            end
        end

        // Five pushes against a stalled peer
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            lk.tx_valid = 1'b1;
            lk.tx_data  = 4'(i);
            step();
        end
        chk("full tx_ready after 4 pushes", lk.tx_ready, 0);
        lk.tx_data = 4'h5;
        step();
        chk("full 5th held", lk.tx_ready, 0);
        chk("full rts", lk.rts, 1);
        chk("full v_in head", lk.v_in, 4'h1);
        lk.cts = 1'b1;
        step();
        chk("full ready after pop", lk.tx_ready, 1);
        lk.cts = 1'b0;
        step();
        chk("full 5th accepted", lk.tx_ready, 0);
        lk.tx_valid = 1'b0;
        tx_expect(4'h2, "drain2");
        tx_expect(4'h3, "drain3");
        tx_expect(4'h4, "drain4");
        tx_expect(4'h5, "drain5");
        chk("drain tx_ready", lk.tx_ready, 1);

        // Timeout with retry and clear semantics
        do_reset();
        lk.timeout_cfg = 8'd3;
        lk.tx_valid    = 1'b1;
        lk.tx_data     = 4'h7;
        step();
        lk.tx_valid = 1'b0;
        hi = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (lk.rts) hi++;
            else if (hi > 0) break;
        end
        chk("timeout rts high cycles", 32'(hi), 3);
        chk("timeout err set", lk.err_timeout, 1);
        chk("timeout rts dropped", lk.rts, 0);
        step();
        chk("timeout retry rts", lk.rts, 1);
        chk("timeout retry word", lk.v_in, 4'h7);
        lk.clr_err = 1'b1;
        step();
        chk("clr_err clears", lk.err_timeout, 0);
        step();
        step();
        chk("timeout with clr same edge", lk.err_timeout, 1);
        chk("second timeout rts", lk.rts, 0);
        step();
        chk("clr_err later clears", lk.err_timeout, 0);
        lk.clr_err     = 1'b0;
        lk.timeout_cfg = 8'd0;
        tx_expect(4'h7, "retry send");
        chk("retry tx empty", lk.tx_ready, 1);

        // Receive FIFO fills, then one pop re-opens the link
        do_reset();
        lk.rx_en = 1'b1;
        w4[0] = 4'h3;
        w4[1] = 4'h9;
        w4[2] = 4'hC;
        w4[3] = 4'h6;
        for (int i = 0; i < 4; i++) rx_give(w4[i], $sformatf("rxfill%0d", i));
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            seen = seen | lk.rtr;
        end
        chk("rx full rtr stays low", seen, 0);
        chk("rx full head", lk.rx_data, 4'h3);
        lk.rx_ready = 1'b1;
        step();
        lk.rx_ready = 1'b0;
        chk("rx pop reopens rtr", lk.rtr, 1);
        chk("rx next head", lk.rx_data, 4'h9);

        // Reset in the middle of a send
        do_reset();
        lk.tx_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            lk.tx_data = 4'(8 + i);
            step();
        end
        lk.tx_valid = 1'b0;
        chk("midreset rts before", lk.rts, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset rts async", lk.rts, 0);
        chk("midreset tx_ready", lk.tx_ready, 1);
        step();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            seen = seen | lk.rts;
        end
        chk("midreset no rts after", seen, 0);

        // Randomized traffic against a queue scoreboard
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            lk.tx_valid = 1'($urandom_range(0, 1));
            lk.tx_data  = 4'($urandom);
            lk.cts      = 1'($urandom_range(0, 1));
            lk.rx_en    = ($urandom_range(0, 3) != 0);
            lk.ctr      = 1'($urandom_range(0, 1));
            lk.v_out    = 4'($urandom);
            lk.rx_ready = ($urandom_range(0, 2) == 0);
            ev_push  = lk.tx_valid && (mtx.size() < 4);
            ev_tdata = lk.tx_data;
            ev_pop   = lk.rts && lk.cts;
            ev_rin   = lk.rtr && lk.ctr;
            ev_vout  = lk.v_out;
            ev_rout  = (mrx.size() > 0) && lk.rx_ready;
            step();
            if (ev_pop && mtx.size() > 0) begin
                void'(mtx.pop_front());
                n_tx++;
            end
            if (ev_push) mtx.push_back(ev_tdata);
            if (ev_rout) void'(mrx.pop_front());
            if (ev_rin) begin
                mrx.push_back(ev_vout);
                n_rx++;
            end
            chk("rnd tx_ready", lk.tx_ready, mtx.size() < 4);
            chk("rnd rx_valid", lk.rx_valid, mrx.size() > 0);
            if (mrx.size() > 0) chk("rnd rx_data", lk.rx_data, mrx[0]);
            if (mtx.size() == 0) chk("rnd rts with nothing queued", lk.rts, 0);
            else if (lk.rts) chk("rnd v_in", lk.v_in, mtx[0]);
            if (mrx.size() == 4) chk("rnd rtr while full", lk.rtr, 0);
            chk("rnd err_timeout", lk.err_timeout, 0);
        end
        chk("rnd send traffic seen", n_tx > 50, 1);
        chk("rnd receive traffic seen", n_rx > 50, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/b10_link_peer.md
B10_LINK_PEER -- requirements
Module: b10_link_peer

Interface
REQ-001 SHALL have ports: clock  in  1  single rising-edge clock; all state in this domain.
REQ-002 SHALL have ports: reset  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: tx_valid  in  1 / tx_data  in  4 / tx_ready  out  1  host-side word push toward the DUT.
REQ-004 SHALL have ports: rx_valid  out  1 / rx_data  out  4 / rx_ready  in  1  host-side word pop from the DUT.
REQ-005 SHALL have ports: rts  out  1 / v_in  out  4 / cts  in  1  send link (peer drives v_in to the DUT).
REQ-006 SHALL have ports: rtr  out  1 / ctr  in  1 / v_out  in  4  receive link (DUT drives v_out).
REQ-007 SHALL have ports: rx_en  in  1  permits receive transactions; timeout_cfg  in  8  handshake timeout in cycles, 0 = disabled.
REQ-008 SHALL have ports: err_timeout  out  1  sticky timeout flag; clr_err  in  1  clears err_timeout.

Function
REQ-009 SHALL hold a 4-entry TX FIFO; tx_ready = not full; push on tx_valid&tx_ready.
REQ-010 SHALL hold a 4-entry RX FIFO; rx_valid = not empty; rx_data = head; pop on rx_valid&rx_ready.
REQ-011 FIFOs SHALL allow simultaneous push and pop, including when full (TX: pop by link) or empty (no pop).
REQ-012 TX FSM states SHALL be TX_IDLE, TX_REQ, TX_REL; rts is registered, high only in TX_REQ.
REQ-013 TX_IDLE -> TX_REQ on the first edge where the TX FIFO is non-empty; a word pushed at edge N into an empty FIFO SHALL raise rts at edge N+1.
REQ-014 v_in SHALL equal the TX FIFO head while in TX_REQ and hold its last value otherwise.
REQ-015 TX_REQ with cts=1 at an edge SHALL pop the TX FIFO, drop rts, go to TX_REL.
REQ-016 TX_REL with cts=0 at an edge SHALL go to TX_IDLE; the next word therefore needs at least 2 edges after release.
REQ-017 RX FSM states SHALL be RX_IDLE, RX_WAIT, RX_REL; rtr is registered, high only in RX_WAIT.
REQ-018 RX_IDLE -> RX_WAIT only when rx_en=1 and the RX FIFO has at least one free entry, counting a same-edge pop.
REQ-019 RX_WAIT with ctr=1 at an edge SHALL push v_out sampled at that edge, drop rtr, go to RX_REL.
REQ-020 RX_REL with ctr=0 SHALL go to RX_IDLE; rx_en deassertion SHALL NOT abort an RX_WAIT in progress.
REQ-021 Per-FSM 8-bit wait counter: cleared on state entry, incremented in TX_REQ/TX_REL/RX_WAIT/RX_REL, saturating at 255.
REQ-022 When timeout_cfg!=0 and the counter reaches timeout_cfg: set err_timeout, go to IDLE, drop the request; the TX word is not popped and is retried; no RX push.
REQ-023 err_timeout SHALL stay set until clr_err; a timeout and clr_err on the same edge SHALL leave it set.
REQ-024 TX and RX FSMs SHALL run independently and concurrently.

Reset
REQ-025 On reset low: both FIFOs empty, both FSMs IDLE, counters 0; outputs rts=0, rtr=0, v_in=0, tx_ready=1, rx_valid=0, rx_data=0, err_timeout=0.
REQ-026 Reset mid-transaction SHALL drop rts/rtr immediately and discard all FIFO contents.

Structure
REQ-027 A shared package b10_link_pkg SHALL hold the FSM state typedefs, FIFO depth (4), and word width (4).
REQ-028 One sub-module b10_link_fifo (parameterised depth/width) SHALL be instantiated for TX and RX.

Verification
REQ-029 Push 4'hA with cts echoing rts after 1 cycle -> rts high at edge N+1, v_in=4'hA, one pop, TX FIFO empty, tx_ready=1 throughout.
REQ-030 Push 5 words while cts=0 -> tx_ready=0 after the 4th push; 5th held until the first handshake completes.
REQ-031 rx_en=1, DUT raises ctr with v_out=4'h5 two cycles after rtr -> rx_valid=1, rx_data=4'h5, rtr low next edge.
REQ-032 timeout_cfg=3, cts stuck 0 -> err_timeout=1 after 3 cycles in TX_REQ, rts drops, then re-asserts with the same word; clr_err clears the flag.
REQ-033 RX FIFO full (4 words, rx_ready=0) -> rtr stays 0; one pop -> rtr rises the following edge.
REQ-034 Assert reset low during TX_REQ with 3 words queued -> rts=0 immediately, tx_ready=1, no further rts after release.
